adc_sampler: RTL
================

// Module: adc_sampler
// PURPOSE
//   Periodic SPI master for a 12-bit serial ADC (16-clock frame, 4 leading zeros, MSB first).
//   Produces one 12-bit unsigned code per sample period plus a 1-cycle strobe.
//   Sits directly upstream of the Kalman filter stage:
//     sample_data  -> origin_data
//     sample_valid -> en_kalman
// PARAMETERS
//   CLK_DIV        4      clk cycles per SCLK half-period; legal range >= 2
//   SAMPLE_PERIOD  50000  clk cycles between sample ticks; must be > 34*CLK_DIV+2
//   LEAD_ZEROS     4      leading frame bits that must read 0
//   FRAME_BITS     16     SCLK rising edges per frame; must equal LEAD_ZEROS+12
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous reset, active low
//   en_sample     in   1   high: sample timer runs
//   adc_miso      in   1   ADC serial data out
//   adc_cs_n      out  1   ADC chip select, active low
//   adc_sclk      out  1   ADC serial clock, idles high
//   sample_data   out  12  last good conversion code
//   sample_valid  out  1   1-cycle pulse: sample_data updated this cycle
//   frame_err     out  1   1-cycle pulse: frame rejected (nonzero leading bit)
//   err_cnt       out  8   rejected-frame count, saturates at 255
// BEHAVIOUR
//   Clock and reset
//     One clock domain. Reset is asynchronous assert, synchronous release.
//     Reset values: adc_cs_n=1, adc_sclk=1, sample_data=0, sample_valid=0, frame_err=0,
//     err_cnt=0. Timer=0, state=IDLE.
//   Sample timer
//     Counts 0..SAMPLE_PERIOD-1 and wraps while en_sample=1.
//     tick = (count==SAMPLE_PERIOD-1) & en_sample.
//     en_sample=0 clears count to 0 and suppresses tick. A frame in progress still completes.
//   FSM IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE
//     IDLE:  on tick, drive adc_cs_n<=0 and go to SETUP.
//     SETUP: wait CLK_DIV cycles, then go to SHIFT with adc_sclk=1.
//     SHIFT: adc_sclk toggles every CLK_DIV cycles; the first toggle is a falling edge.
//            On each clk edge that drives adc_sclk 0->1, shift adc_miso into a 16-bit
//            register (MSB first).
//            After FRAME_BITS rising edges, adc_sclk stays 1; go to HOLD.
//     HOLD:  wait CLK_DIV cycles, then drive adc_cs_n<=1 and go to DONE.
//     DONE:  evaluate the frame for one cycle, then return to IDLE.
//   Frame evaluation (in DONE)
//     Leading LEAD_ZEROS bits all 0:
//       sample_data<=shift[11:0]; sample_valid=1 for exactly one cycle.
//     Any leading bit 1:
//       frame_err=1 for one cycle; sample_data holds its value; err_cnt+=1 (stops at 255).
//     sample_valid and frame_err are never high together.
//   Latency and spacing
//     Tick cycle to sample_valid/frame_err = 34*CLK_DIV+1 clk cycles, fixed.
//     adc_cs_n is low for 34*CLK_DIV cycles per frame.
//     Strobes are SAMPLE_PERIOD cycles apart. A tick never lands outside IDLE because of the
//     SAMPLE_PERIOD bound.
//   Boundaries
//     Codes 0x000 and 0xFFF pass unchanged; no sign handling (unsigned code).
//     en_sample toggling mid-frame has no effect on that frame.
//     Reset mid-frame aborts it immediately: cs_n=1, sclk=1, no strobe.
//       After release, the first tick comes SAMPLE_PERIOD cycles after en_sample is seen high.
// TESTING (CLK_DIV=4, SAMPLE_PERIOD=200, ADC model drives MISO on SCLK falling edge)
//   1 Model frame 0x0ABC -> one sample_valid 137 cycles after tick; sample_data=0xABC;
//     16 SCLK rising edges; cs_n low 136 cycles.
//   2 Frame 0x8123 after test 1 -> frame_err pulse; no sample_valid; sample_data stays 0xABC;
//     err_cnt=1.
//   3 Frames 0x0000 then 0x0FFF -> sample_data 0x000 then 0xFFF; strobes exactly 200 cycles
//     apart.
//   4 en_sample dropped 20 cycles into SHIFT -> frame completes with valid;
//     no further cs_n activity.
//   5 rst_n low mid-SHIFT -> cs_n=1, sclk=1, all outputs 0 asynchronously; no stray strobe
//     after release.
//   6 300 consecutive bad frames -> err_cnt=255 and holds; a later good frame still gives
//     sample_valid.

Source files
------------

// File: rtl/adc_sampler.sv
// Periodic SPI master for a 12-bit serial ADC: one framed conversion per sample period,
// leading-zero check, 1-cycle valid/error strobes and a saturating rejected-frame counter.
module adc_sampler #(
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned SAMPLE_PERIOD = 50000,
   parameter int unsigned LEAD_ZEROS    = 4,
   parameter int unsigned FRAME_BITS    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_sample,
   input  logic        adc_miso,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [11:0] sample_data,
   output logic        sample_valid,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam int unsigned TW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned DW     = $clog2(CLK_DIV);
   localparam int unsigned BW     = $clog2(FRAME_BITS + 1);
   localparam int unsigned CODE_W = 12;
   localparam int unsigned ERR_W  = 8;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   logic [TW-1:0] count;
   logic          tick_c;

   // Sample timer: free-running while enabled, held at zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!en_sample) begin
         count <= '0;
      end else if (count == TW'(SAMPLE_PERIOD - 1)) begin
         count <= '0;
      end else begin
         count <= count + TW'(1);
      end
   end

   assign tick_c = en_sample && (count == TW'(SAMPLE_PERIOD - 1));

   state_t                 state, state_d;
   logic [DW-1:0]          div_cnt, div_d;
   logic [BW-1:0]          bit_cnt, bit_d;
   logic [FRAME_BITS-1:0]  shift, shift_d;
   logic                   cs_d, sclk_d, valid_d, err_d;
   logic [CODE_W-1:0]      data_d;
   logic [ERR_W-1:0]       errc_d;
   logic                   div_last_c;

   assign div_last_c = (div_cnt == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b1;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         err_cnt      <= '0;
      end else begin
         state        <= state_d;
         div_cnt      <= div_d;
         bit_cnt      <= bit_d;
         shift        <= shift_d;
         adc_cs_n     <= cs_d;
         adc_sclk     <= sclk_d;
         sample_data  <= data_d;
         sample_valid <= valid_d;
         frame_err    <= err_d;
         err_cnt      <= errc_d;
      end
   end

   // Strobes are registered on HOLD exit so they are visible during the DONE cycle.
   always_comb begin
      state_d = state;
      div_d   = div_cnt;
      bit_d   = bit_cnt;
      shift_d = shift;
      cs_d    = adc_cs_n;
      sclk_d  = adc_sclk;
      data_d  = sample_data;
      valid_d = 1'b0;
      err_d   = 1'b0;
      errc_d  = err_cnt;
      case (state)
         IDLE: begin
            if (tick_c) begin
               cs_d    = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            div_d = div_cnt + DW'(1);
            if (div_last_c) begin
               div_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            div_d = div_cnt + DW'(1);
            if (div_last_c) begin
               div_d  = '0;
               sclk_d = ~adc_sclk;
               if (!adc_sclk) begin
                  shift_d = {shift[FRAME_BITS-2:0], adc_miso};
                  bit_d   = bit_cnt + BW'(1);
                  if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            div_d = div_cnt + DW'(1);
            if (div_last_c) begin
               div_d   = '0;
               cs_d    = 1'b1;
               state_d = DONE;
               if (shift[FRAME_BITS-1 -: LEAD_ZEROS] == '0) begin
                  data_d  = shift[CODE_W-1:0];
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
                  if (err_cnt != {ERR_W{1'b1}}) begin
                     errc_d = err_cnt + ERR_W'(1);
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
